// File: rtl/cascade_pkg.sv
// Shared types and elaboration helpers for the window scan / classifier front end.
package cascade_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_state_t;

    typedef struct packed {
        logic last_win;
        logic last_img;
    } win_flags_t;

    // Number of window positions along one axis for a given frame size, window and stride.
    function automatic int n_windows(input int img, input int win, input int step);
        return (img - win) / step + 1;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop frees the slot for a same-cycle push when full.
module sync_fifo
    import cascade_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int W_PTR = cnt_width(DEPTH);
    localparam int W_CNT = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [W_PTR-1:0] wr_ptr;
    logic [W_PTR-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == W_CNT'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/window_reader.sv
// Scans every WIN x WIN sub-window of a loaded frame, fetching pixels from image_buffer
// and streaming them downstream tagged with window and frame end markers.
module window_reader
    import cascade_pkg::*;
#(
    parameter int W_DATA     = 8,
    parameter int IMG_WIDTH  = 45,
    parameter int IMG_HEIGHT = 45,
    parameter int WIN        = 24,
    parameter int STEP       = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int W_ADDR    = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [W_ADDR-1:0] addr_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [W_DATA-1:0] pix_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [W_DATA-1:0] dout_data,
    output logic              dout_last_win,
    output logic              dout_last_img,
    output logic              busy
);

    localparam int N_WIN_X = n_windows(IMG_WIDTH, WIN, STEP);
    localparam int N_WIN_Y = n_windows(IMG_HEIGHT, WIN, STEP);
    localparam int W_POS   = cnt_width(WIN);
    localparam int W_WX    = cnt_width(N_WIN_X);
    localparam int W_WY    = cnt_width(N_WIN_Y);
    localparam int W_CNT   = $clog2(FIFO_DEPTH + 1);

    localparam logic [W_ADDR-1:0] ROW_INC  = W_ADDR'(IMG_WIDTH);
    localparam logic [W_ADDR-1:0] WX_INC   = W_ADDR'(STEP);
    localparam logic [W_ADDR-1:0] WY_INC   = W_ADDR'(STEP * IMG_WIDTH);
    localparam logic [W_POS-1:0]  POS_LAST = W_POS'(WIN - 1);
    localparam logic [W_WX-1:0]   WX_LAST  = W_WX'(N_WIN_X - 1);
    localparam logic [W_WY-1:0]   WY_LAST  = W_WY'(N_WIN_Y - 1);

    typedef struct packed {
        logic [W_DATA-1:0] data;
        win_flags_t        flags;
    } pix_beat_t;

    rd_state_t         state;
    rd_state_t         state_next;

    logic [W_POS-1:0]  col;
    logic [W_POS-1:0]  row;
    logic [W_WX-1:0]   win_x;
    logic [W_WY-1:0]   win_y;
    logic [W_ADDR-1:0] win_row_base;
    logic [W_ADDR-1:0] win_base;
    logic [W_ADDR-1:0] row_base;
    logic [W_ADDR-1:0] addr_cur;

    logic [W_CNT-1:0]  outstanding;
    logic [W_CNT-1:0]  ret_count;
    logic [W_CNT-1:0]  flag_count;
    logic [W_CNT:0]    in_flight;

    logic              start_fire;
    logic              addr_fire;
    logic              pix_accept;
    logic              dout_fire;
    logic              ret_empty;
    logic              ret_full;
    logic              flag_empty;
    logic              flag_full;
    logic              unused_status;

    win_flags_t        issue_flags;
    win_flags_t        return_flags;
    pix_beat_t         ret_in;
    pix_beat_t         ret_head;

    assign start_ready = (state == IDLE);
    assign start_fire  = start_valid && start_ready;
    assign busy        = (state != IDLE);

    // Every in-flight request already owns a return FIFO slot, so returns never need backpressure.
    assign in_flight   = {1'b0, outstanding} + {1'b0, ret_count};
    assign addr_valid  = (state == ISSUE) && (in_flight < (W_CNT + 1)'(FIFO_DEPTH));
    assign addr_fire   = addr_valid && addr_ready;
    assign addr_data   = addr_cur;

    assign pix_ready   = 1'b1;
    assign pix_accept  = pix_valid && (outstanding != '0);

    assign dout_valid    = !ret_empty;
    assign dout_fire     = dout_valid && dout_ready;
    assign dout_data     = ret_head.data;
    assign dout_last_win = !ret_empty && ret_head.flags.last_win;
    assign dout_last_img = !ret_empty && ret_head.flags.last_img;

    assign issue_flags.last_win = (col == POS_LAST) && (row == POS_LAST);
    assign issue_flags.last_img = issue_flags.last_win && (win_x == WX_LAST) && (win_y == WY_LAST);

    assign ret_in.data  = pix_data;
    assign ret_in.flags = return_flags;

    assign unused_status = ^{flag_count, flag_full, flag_empty, ret_full};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain ends on the frame's final beat, which by then is the only thing left in the pipe.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_fire) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (addr_fire && issue_flags.last_img) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (dout_fire && ret_head.flags.last_img && (outstanding == '0)
                    && (ret_count == W_CNT'(1))) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({addr_fire, pix_accept})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Addresses advance by accumulation: +1 per column, +IMG_WIDTH per row, +STEP per window
    // across, +STEP*IMG_WIDTH per window row down.
    always_ff @(posedge clk) begin
        if (rst || start_fire) begin
            col          <= '0;
            row          <= '0;
            win_x        <= '0;
            win_y        <= '0;
            win_row_base <= '0;
            win_base     <= '0;
            row_base     <= '0;
            addr_cur     <= '0;
        end else if (addr_fire && !issue_flags.last_img) begin
            if (col != POS_LAST) begin
                col      <= col + 1'b1;
                addr_cur <= addr_cur + 1'b1;
            end else if (row != POS_LAST) begin
                col      <= '0;
                row      <= row + 1'b1;
                row_base <= row_base + ROW_INC;
                addr_cur <= row_base + ROW_INC;
            end else begin
                col <= '0;
                row <= '0;
                if (win_x != WX_LAST) begin
                    win_x    <= win_x + 1'b1;
                    win_base <= win_base + WX_INC;
                    row_base <= win_base + WX_INC;
                    addr_cur <= win_base + WX_INC;
                end else begin
                    win_x        <= '0;
                    win_y        <= win_y + 1'b1;
                    win_row_base <= win_row_base + WY_INC;
                    win_base     <= win_row_base + WY_INC;
                    row_base     <= win_row_base + WY_INC;
                    addr_cur     <= win_row_base + WY_INC;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(win_flags_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_flag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (addr_fire),
        .push_data (issue_flags),
        .pop       (pix_accept),
        .head      (return_flags),
        .empty     (flag_empty),
        .full      (flag_full),
        .count     (flag_count)
    );

    sync_fifo #(
        .WIDTH ($bits(pix_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_ret_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pix_accept),
        .push_data (ret_in),
        .pop       (dout_fire),
        .head      (ret_head),
        .empty     (ret_empty),
        .full      (ret_full),
        .count     (ret_count)
    );

endmodule

// File: tb/tb_window_reader.sv
// Scoreboard bench for window_reader: a 6x5/WIN3/STEP2 instance for the scan cases and a
// 3x3/WIN3 instance for the single-window case.
module tb_window_reader;

    typedef struct {
        int data;
        bit lw;
        bit li;
    } beat_t;

    typedef struct {
        int addr;
        int due;
    } mreq_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start_valid = 1'b0;
    logic       start_ready;
    logic       addr_valid;
    logic       addr_ready = 1'b1;
    logic [4:0] addr_data;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [7:0] pix_data = 8'd0;
    logic       dout_valid;
    logic       dout_ready = 1'b1;
    logic [7:0] dout_data;
    logic       dout_last_win;
    logic       dout_last_img;
    logic       busy;

    logic       s_start_valid = 1'b0;
    logic       s_start_ready;
    logic       s_addr_valid;
    logic [3:0] s_addr_data;
    logic       s_pix_valid = 1'b0;
    logic       s_pix_ready;
    logic [7:0] s_pix_data = 8'd0;
    logic       s_dout_valid;
    logic [7:0] s_dout_data;
    logic       s_dout_last_win;
    logic       s_dout_last_img;
    logic       s_busy;

    int    checks_total = 0;
    int    checks_pass  = 0;
    beat_t exp_q[$];
    int    exp_addr_q[$];
    mreq_t mem_q[$];
    int    mcyc = 0;
    int    lat = 1;
    bit    rand_dout = 1'b0;
    bit    rand_addr = 1'b0;
    int    issued = 0;
    int    consumed = 0;
    int    inflight_snap = 0;
    int    beats = 0;
    bit    prev_stall = 1'b0;
    int    prev_addr = 0;

    bit    s_pend_v = 1'b0;
    int    s_pend_a = 0;
    int    s_beats = 0;
    int    s_addr_cnt = 0;

    int addr_tab[36] = '{0, 1, 2, 6, 7, 8, 12, 13, 14,
                         2, 3, 4, 8, 9, 10, 14, 15, 16,
                         12, 13, 14, 18, 19, 20, 24, 25, 26,
                         14, 15, 16, 20, 21, 22, 26, 27, 28};

    always #5 clk = ~clk;

    window_reader #(
        .W_DATA(8), .IMG_WIDTH(6), .IMG_HEIGHT(5), .WIN(3), .STEP(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_data(addr_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_last_win(dout_last_win), .dout_last_img(dout_last_img),
        .busy(busy)
    );

    window_reader #(
        .W_DATA(8), .IMG_WIDTH(3), .IMG_HEIGHT(3), .WIN(3), .STEP(1), .FIFO_DEPTH(4)
    ) dut_s (
        .clk(clk), .rst(rst),
        .start_valid(s_start_valid), .start_ready(s_start_ready),
        .addr_valid(s_addr_valid), .addr_ready(1'b1), .addr_data(s_addr_data),
        .pix_valid(s_pix_valid), .pix_ready(s_pix_ready), .pix_data(s_pix_data),
        .dout_valid(s_dout_valid), .dout_ready(1'b1), .dout_data(s_dout_data),
        .dout_last_win(s_dout_last_win), .dout_last_img(s_dout_last_img),
        .busy(s_busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Memory model and input randomisation, applied just after each rising edge.
    always @(posedge clk) begin
        #1;
        mcyc++;
        inflight_snap = issued - consumed;
        pix_valid = 1'b0;
        pix_data  = 8'd0;
        if (mem_q.size() > 0 && mem_q[0].due <= mcyc) begin
            pix_valid = 1'b1;
            pix_data  = 8'(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        addr_ready = rand_addr ? ($urandom_range(0, 1) == 1) : 1'b1;
        dout_ready = rand_dout ? ($urandom_range(0, 1) == 1) : 1'b1;
        s_pix_valid = s_pend_v;
        s_pix_data  = 8'(s_pend_a);
        s_pend_v    = 1'b0;
    end

    // Address channel monitor: order, stall stability and credit limit.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid_held", int'(addr_valid), 1);
                checkOutput("stall_addr_held", int'(addr_data), prev_addr);
            end
            if (inflight_snap >= 4) begin
                checkOutput("credit_stop", int'(addr_valid), 0);
            end
            prev_stall = addr_valid && !addr_ready;
            prev_addr  = int'(addr_data);
            if (addr_valid && addr_ready) begin
                mreq_t r;
                checkOutput("credit_limit", int'(inflight_snap < 4), 1);
                if (exp_addr_q.size() == 0) begin
                    checkOutput("addr_unexpected", int'(addr_data), -1);
                end else begin
                    checkOutput("addr_seq", int'(addr_data), exp_addr_q.pop_front());
                end
                r.addr = int'(addr_data);
                r.due  = mcyc + lat;
                mem_q.push_back(r);
                issued++;
            end
        end
    end

    // Output monitor: pops the scoreboard on every downstream handshake.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            consumed++;
            beats++;
            if (exp_q.size() == 0) begin
                checkOutput("beat_unexpected", int'(dout_data), -1);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                checkOutput("dout_data", int'(dout_data), e.data);
                checkOutput("dout_last_win", int'(dout_last_win), int'(e.lw));
                checkOutput("dout_last_img", int'(dout_last_img), int'(e.li));
            end
        end
    end

    // Single-window instance: 1-cycle memory, always-ready consumer.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_addr_valid) begin
                checkOutput("s_addr_seq", int'(s_addr_data), s_addr_cnt);
                s_addr_cnt++;
                s_pend_v = 1'b1;
                s_pend_a = int'(s_addr_data);
            end
            if (s_dout_valid) begin
                checkOutput("s_dout_data", int'(s_dout_data), s_beats);
                checkOutput("s_last_win", int'(s_dout_last_win), int'(s_beats == 8));
                checkOutput("s_last_img", int'(s_dout_last_img), int'(s_beats == 8));
                s_beats++;
            end
        end
    end

    task automatic startScan(input bit rd, input bit ra, input int l);
        rand_dout = rd;
        rand_addr = ra;
        lat       = l;
        for (int i = 0; i < 36; i++) begin
            beat_t b;
            b.data = addr_tab[i];
            b.lw   = ((i % 9) == 8);
            b.li   = (i == 35);
            exp_q.push_back(b);
            exp_addr_q.push_back(addr_tab[i]);
        end
        beats = 0;
        @(posedge clk);
        #1 start_valid = 1'b1;
        @(negedge clk);
        checkOutput("start_ready_idle", int'(start_ready), 1);
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_start", int'(busy), 1);
    endtask

    task automatic finishScan();
        int n;
        n = 0;
        while (n < 3000 && !(beats == 36 && !busy)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scan_done_in_time", int'(n < 3000), 1);
        @(negedge clk);
        checkOutput("beat_count", beats, 36);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        checkOutput("addr_queue_empty", exp_addr_q.size(), 0);
        checkOutput("idle_start_ready", int'(start_ready), 1);
        checkOutput("idle_dout_valid", int'(dout_valid), 0);
        rand_dout = 1'b0;
        rand_addr = 1'b0;
    endtask

    task automatic applyStimulus(input bit rd, input bit ra, input int l);
        startScan(rd, ra, l);
        finishScan();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_addr_valid", int'(addr_valid), 0);
        checkOutput("rst_dout_valid", int'(dout_valid), 0);
        checkOutput("rst_last_win", int'(dout_last_win), 0);
        checkOutput("rst_last_img", int'(dout_last_img), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_start_ready", int'(start_ready), 1);
        checkOutput("rst_pix_ready", int'(pix_ready), 1);

        $display("[TB] case 1: full throughput");
        applyStimulus(1'b0, 1'b0, 1);
        $display("[TB] case 2: random downstream backpressure");
        applyStimulus(1'b1, 1'b0, 1);
        $display("[TB] case 3: random address stalls");
        applyStimulus(1'b0, 1'b1, 1);
        $display("[TB] case 4: 3-cycle memory latency");
        applyStimulus(1'b0, 1'b0, 3);

        $display("[TB] case 5: reset mid-scan");
        startScan(1'b0, 1'b0, 3);
        n = 0;
        while (n < 500 && beats < 12) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_beat_12", int'(beats >= 12), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_dout_valid", int'(dout_valid), 0);
        checkOutput("midrst_addr_valid", int'(addr_valid), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_start_ready", int'(start_ready), 1);
        repeat (6) begin
            @(negedge clk);
            checkOutput("late_pix_dropped", int'(dout_valid), 0);
        end
        checkOutput("late_pix_delivered", mem_q.size(), 0);
        mem_q.delete();
        issued   = 0;
        consumed = 0;
        applyStimulus(1'b0, 1'b0, 1);

        $display("[TB] case 6: single 3x3 window");
        @(posedge clk);
        #1 s_start_valid = 1'b1;
        @(posedge clk);
        #1 s_start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 s_start_valid = 1'b1;
        @(negedge clk);
        checkOutput("s_busy_mid", int'(s_busy), 1);
        checkOutput("s_start_ready_busy", int'(s_start_ready), 0);
        @(posedge clk);
        #1 s_start_valid = 1'b0;
        n = 0;
        while (n < 300 && !(s_beats == 9 && !s_busy)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("s_done_in_time", int'(n < 300), 1);
        repeat (10) @(negedge clk);
        checkOutput("s_beat_count", s_beats, 9);
        checkOutput("s_addr_count", s_addr_cnt, 9);
        checkOutput("s_idle", int'(s_busy), 0);

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
